// File: rtl/axi_stream_packet_arbiter.sv
// ---------------------------------------------------------------------------
// axi_stream_packet_arbiter
//
// Packet-granular round-robin arbiter. It merges NUM_INPUTS 32-bit AXI Stream
// sources into one stream that feeds the packet combiner. A grant is held for
// a whole packet, so packets never interleave. Packets longer than
// MAX_PKT_LEN words are cut short: the rest of the packet is accepted and
// thrown away. A flush timer raises force_transmit so that slow traffic is
// not held in the combiner for ever.
//
// Ports:
//   clk, rst         : clock and synchronous active-high reset
//   in_tdata         : source data; source i occupies bits [32*i+31:32*i]
//   in_tvalid        : per-source valid
//   in_tlast         : per-source end of packet
//   in_tready        : per-source ready
//   out_tdata        : data from the granted source (combinational)
//   out_tvalid       : valid from the granted source (combinational)
//   out_tlast        : end of packet, or a forced last when truncating
//   out_tready       : ready from the combiner
//   force_transmit   : one-cycle flush request to the combiner
//   grant_id         : source that holds the grant now, or held it last
//   trunc_err        : one-cycle pulse on the word where a packet is cut
// ---------------------------------------------------------------------------
module axi_stream_packet_arbiter #(
  parameter int NUM_INPUTS    = 4,
  parameter int MAX_PKT_LEN   = 64,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_INPUTS*32-1:0]      in_tdata,
  input  logic [NUM_INPUTS-1:0]         in_tvalid,
  input  logic [NUM_INPUTS-1:0]         in_tlast,
  output logic [NUM_INPUTS-1:0]         in_tready,
  output logic [31:0]                   out_tdata,
  output logic                          out_tvalid,
  output logic                          out_tlast,
  input  logic                          out_tready,
  output logic                          force_transmit,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_id,
  output logic                          trunc_err
);

  localparam int GW = $clog2(NUM_INPUTS);
  localparam int CW = $clog2(MAX_PKT_LEN + 1);
  localparam int TW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [GW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Per-source view of the flat data bus.
  logic [31:0] src_data [NUM_INPUTS];

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_src
      assign src_data[gi] = in_tdata[32*gi +: 32];
    end
  endgenerate

  logic [31:0] sel_data;
  logic        sel_valid;
  logic        sel_last;
  logic        at_max;

  assign sel_data  = src_data[g_q];
  assign sel_valid = in_tvalid[g_q];
  assign sel_last  = in_tlast[g_q];
  // The word now on offer is the last one the packet may carry.
  assign at_max    = (cnt_q == CW'(MAX_PKT_LEN - 1));

  // Round-robin pick: first valid source after last_q, going round the ring.
  // last_q itself is tried last, so a lone source can be granted again.
  logic          rr_found;
  logic [GW-1:0] rr_idx;

  always_comb begin
    int          c;
    logic [GW-1:0] cand;
    rr_found = 1'b0;
    rr_idx   = '0;
    c        = 0;
    cand     = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      c    = (int'(last_q) + k) % NUM_INPUTS;
      cand = GW'(c);
      if (!rr_found && in_tvalid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= GW'(NUM_INPUTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          g_d     = rr_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (sel_valid && out_tready) begin
          cnt_d = cnt_q + CW'(1);
          // A real tlast on the final allowed word is a normal end.
          if (sel_last) begin
            last_d  = g_q;
            state_d = IDLE;
          end else if (at_max) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // in_tready is held high here, so every valid word is a transfer.
        if (sel_valid && sel_last) begin
          last_d  = g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Every output is forced low while rst is high, even before
  // the registers have taken their reset values.
  always_comb begin
    in_tready  = '0;
    out_tdata  = '0;
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    trunc_err  = 1'b0;
    grant_id   = '0;
    if (!rst) begin
      grant_id = g_q;
      case (state_q)
        GRANT: begin
          in_tready[g_q] = out_tready;
          out_tdata      = sel_data;
          out_tvalid     = sel_valid;
          out_tlast      = sel_last | at_max;
          trunc_err      = sel_valid & out_tready & at_max & ~sel_last;
        end
        DRAIN: begin
          in_tready[g_q] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic xfer_out;
  assign xfer_out = out_tvalid & out_tready;

  // Flush timer: starts counting on the cycle after the first word sent
  // since the last flush, and fires FLUSH_TIMEOUT cycles after that word.
  generate
    if (FLUSH_TIMEOUT > 0) begin : g_flush
      logic [TW-1:0] timer_q;
      logic          pending_q;
      logic          hit;

      assign hit = pending_q && (timer_q == TW'(FLUSH_TIMEOUT - 1));

      always_ff @(posedge clk) begin
        if (rst) begin
          timer_q   <= '0;
          pending_q <= 1'b0;
        end else if (hit) begin
          timer_q   <= '0;
          // A word sent in the flush cycle starts the next interval.
          pending_q <= xfer_out;
        end else begin
          if (pending_q) begin
            timer_q <= timer_q + TW'(1);
          end
          if (xfer_out) begin
            pending_q <= 1'b1;
          end
        end
      end

      assign force_transmit = hit & ~rst;
    end else begin : g_no_flush
      logic unused_xfer;
      assign unused_xfer    = xfer_out;
      assign force_transmit = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for axi_stream_packet_arbiter: directed vectors from a table,
// then hand-written sequences for flush timing and round-robin fairness.
// A second instance with flushing disabled shares the inputs of the main one.
// ---------------------------------------------------------------------------
module tb_axi_stream_packet_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_tdata;
  logic [3:0]   in_tvalid;
  logic [3:0]   in_tlast;
  logic [3:0]   in_tready;
  logic [31:0]  out_tdata;
  logic         out_tvalid;
  logic         out_tlast;
  logic         out_tready;
  logic         force_transmit;
  logic [1:0]   grant_id;
  logic         trunc_err;

  logic [3:0]   nf_in_tready;
  logic [31:0]  nf_out_tdata;
  logic         nf_out_tvalid;
  logic         nf_out_tlast;
  logic         nf_force_transmit;
  logic [1:0]   nf_grant_id;
  logic         nf_trunc_err;

  always #5 clk = ~clk;

  axi_stream_packet_arbiter #(
    .NUM_INPUTS(4), .MAX_PKT_LEN(4), .FLUSH_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
    .out_tready(out_tready),
    .force_transmit(force_transmit), .grant_id(grant_id), .trunc_err(trunc_err)
  );

  axi_stream_packet_arbiter #(
    .NUM_INPUTS(4), .MAX_PKT_LEN(4), .FLUSH_TIMEOUT(0)
  ) dut_nf (
    .clk(clk), .rst(rst),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(nf_in_tready),
    .out_tdata(nf_out_tdata), .out_tvalid(nf_out_tvalid), .out_tlast(nf_out_tlast),
    .out_tready(out_tready),
    .force_transmit(nf_force_transmit), .grant_id(nf_grant_id), .trunc_err(nf_trunc_err)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic        ordy;
    logic [7:0]  word;
    logic [3:0]  irdy;
    logic        ovld;
    logic        olast;
    logic [31:0] odata;
    logic [1:0]  gid;
    logic        terr;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Every source presents {source id, 20'b0, word}.
  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic ordy, input logic [7:0] w);
    rst        = r;
    in_tvalid  = v;
    in_tlast   = l;
    out_tready = ordy;
    for (int s = 0; s < 4; s++) in_tdata[32*s +: 32] = (32'(s) << 28) | 32'(w);
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l,
                     input logic ordy, input logic [7:0] w,
                     input logic [3:0] irdy, input logic ovld, input logic olast,
                     input logic [31:0] odata, input logic [1:0] gid, input logic terr);
    vec_t t;
    t.rst = r; t.vld = v; t.lst = l; t.ordy = ordy; t.word = w;
    t.irdy = irdy; t.ovld = ovld; t.olast = olast; t.odata = odata;
    t.gid = gid; t.terr = terr;
    vecs.push_back(t);
  endtask

  int w_idx [4];
  logic [3:0] adv;

  initial begin
    drive(1'b1, 4'b0000, 4'b0000, 1'b1, 8'd0);

    // reset, with and without valid requests
    add(1, 4'b0000, 4'b0000, 1, 0,  4'b0000, 0, 0, 32'h0, 0, 0);
    add(1, 4'b1111, 4'b0000, 1, 0,  4'b0000, 0, 0, 32'h0, 0, 0);
    // single source 2, two 1-word packets
    add(0, 4'b0100, 4'b0100, 1, 1,  4'b0000, 0, 0, 32'h0, 0, 0);
    add(0, 4'b0100, 4'b0100, 1, 1,  4'b0100, 1, 1, 32'h2000_0001, 2, 0);
    add(0, 4'b0100, 4'b0100, 1, 2,  4'b0000, 0, 0, 32'h0, 2, 0);
    add(0, 4'b0100, 4'b0100, 1, 2,  4'b0100, 1, 1, 32'h2000_0002, 2, 0);
    // exact length: source 0, 4 words, tlast on word 4
    add(0, 4'b0001, 4'b0000, 1, 0,  4'b0000, 0, 0, 32'h0, 2, 0);
    add(0, 4'b0001, 4'b0000, 1, 1,  4'b0001, 1, 0, 32'h0000_0001, 0, 0);
    add(0, 4'b0001, 4'b0000, 1, 2,  4'b0001, 1, 0, 32'h0000_0002, 0, 0);
    add(0, 4'b0001, 4'b0000, 1, 3,  4'b0001, 1, 0, 32'h0000_0003, 0, 0);
    add(0, 4'b0001, 4'b0001, 1, 4,  4'b0001, 1, 1, 32'h0000_0004, 0, 0);
    add(0, 4'b0000, 4'b0000, 1, 0,  4'b0000, 0, 0, 32'h0, 0, 0);
    // truncation: source 1 sends 7 words, source 2 waiting
    add(0, 4'b0110, 4'b0100, 1, 1,  4'b0000, 0, 0, 32'h0, 0, 0);
    add(0, 4'b0110, 4'b0100, 1, 1,  4'b0010, 1, 0, 32'h1000_0001, 1, 0);
    add(0, 4'b0110, 4'b0100, 1, 2,  4'b0010, 1, 0, 32'h1000_0002, 1, 0);
    add(0, 4'b0110, 4'b0100, 1, 3,  4'b0010, 1, 0, 32'h1000_0003, 1, 0);
    add(0, 4'b0110, 4'b0100, 1, 4,  4'b0010, 1, 1, 32'h1000_0004, 1, 1);
    add(0, 4'b0110, 4'b0100, 1, 5,  4'b0010, 0, 0, 32'h0, 1, 0);
    add(0, 4'b0110, 4'b0100, 1, 6,  4'b0010, 0, 0, 32'h0, 1, 0);
    add(0, 4'b0110, 4'b0110, 1, 7,  4'b0010, 0, 0, 32'h0, 1, 0);
    add(0, 4'b0100, 4'b0100, 1, 9,  4'b0000, 0, 0, 32'h0, 1, 0);
    add(0, 4'b0100, 4'b0100, 1, 9,  4'b0100, 1, 1, 32'h2000_0009, 2, 0);
    // backpressure on source 3, including a valid gap mid-packet
    add(0, 4'b1000, 4'b0000, 1, 1,  4'b0000, 0, 0, 32'h0, 2, 0);
    add(0, 4'b1000, 4'b0000, 1, 1,  4'b1000, 1, 0, 32'h3000_0001, 3, 0);
    add(0, 4'b1000, 4'b0000, 0, 2,  4'b0000, 1, 0, 32'h3000_0002, 3, 0);
    add(0, 4'b1000, 4'b0000, 1, 2,  4'b1000, 1, 0, 32'h3000_0002, 3, 0);
    add(0, 4'b0001, 4'b0000, 1, 3,  4'b1000, 0, 0, 32'h0, 3, 0);
    add(0, 4'b1000, 4'b0000, 0, 3,  4'b0000, 1, 0, 32'h3000_0003, 3, 0);
    add(0, 4'b1000, 4'b0000, 1, 3,  4'b1000, 1, 0, 32'h3000_0003, 3, 0);
    add(0, 4'b1000, 4'b1000, 0, 4,  4'b0000, 1, 1, 32'h3000_0004, 3, 0);
    add(0, 4'b1000, 4'b1000, 1, 4,  4'b1000, 1, 1, 32'h3000_0004, 3, 0);
    add(0, 4'b0000, 4'b0000, 1, 0,  4'b0000, 0, 0, 32'h0, 3, 0);
    // reset after word 2 of a packet from source 1
    add(0, 4'b0010, 4'b0000, 1, 1,  4'b0000, 0, 0, 32'h0, 3, 0);
    add(0, 4'b0010, 4'b0000, 1, 1,  4'b0010, 1, 0, 32'h1000_0001, 1, 0);
    add(0, 4'b0010, 4'b0000, 1, 2,  4'b0010, 1, 0, 32'h1000_0002, 1, 0);
    add(1, 4'b0010, 4'b0000, 1, 3,  4'b0000, 0, 0, 32'h0, 0, 0);
    add(0, 4'b0011, 4'b0001, 1, 5,  4'b0000, 0, 0, 32'h0, 0, 0);
    add(0, 4'b0011, 4'b0001, 1, 5,  4'b0001, 1, 1, 32'h0000_0005, 0, 0);
    add(0, 4'b0000, 4'b0000, 1, 0,  4'b0000, 0, 0, 32'h0, 0, 0);

    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].lst, vecs[i].ordy, vecs[i].word);
      @(negedge clk);
      chk($sformatf("v%0d in_tready", i),  32'(in_tready),  32'(vecs[i].irdy));
      chk($sformatf("v%0d out_tvalid", i), 32'(out_tvalid), 32'(vecs[i].ovld));
      chk($sformatf("v%0d out_tlast", i),  32'(out_tlast),  32'(vecs[i].olast));
      chk($sformatf("v%0d grant_id", i),   32'(grant_id),   32'(vecs[i].gid));
      chk($sformatf("v%0d trunc_err", i),  32'(trunc_err),  32'(vecs[i].terr));
      if (vecs[i].ovld || vecs[i].rst)
        chk($sformatf("v%0d out_tdata", i), out_tdata, vecs[i].odata);
      @(posedge clk); #1;
    end

    // Flush timer: quiet period, then one word; pulse due 8 cycles later.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 4'b0000, 4'b0000, 1'b1, 8'd0);
      @(posedge clk); #1;
    end
    for (int s = 0; s < 26; s++) begin
      if (s < 2) drive(1'b0, 4'b0001, 4'b0001, 1'b1, 8'h77);
      else       drive(1'b0, 4'b0000, 4'b0000, 1'b1, 8'h00);
      @(negedge clk);
      if (s == 1) chk("flush word out_tvalid", 32'(out_tvalid), 32'd1);
      chk($sformatf("flush s%0d force_transmit", s), 32'(force_transmit), 32'(s == 9));
      chk($sformatf("flush s%0d nf force_transmit", s), 32'(nf_force_transmit), 32'd0);
      @(posedge clk); #1;
    end

    // Fairness: all four sources stream 3-word packets back to back.
    drive(1'b1, 4'b0000, 4'b0000, 1'b1, 8'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++) w_idx[s] = 1;
    for (int c = 0; c < 32; c++) begin
      int phase;
      int src;
      phase = c % 4;
      src   = (c / 4) % 4;
      rst = 1'b0; out_tready = 1'b1; in_tvalid = 4'hF;
      for (int s = 0; s < 4; s++) begin
        in_tdata[32*s +: 32] = (32'(s) << 28) | 32'(w_idx[s]);
        in_tlast[s]          = (w_idx[s] == 3);
      end
      @(negedge clk);
      chk($sformatf("rr c%0d out_tvalid", c), 32'(out_tvalid), 32'(phase != 0));
      if (phase != 0) begin
        chk($sformatf("rr c%0d out_tdata", c), out_tdata, (32'(src) << 28) | 32'(phase));
        chk($sformatf("rr c%0d out_tlast", c), 32'(out_tlast), 32'(phase == 3));
        chk($sformatf("rr c%0d grant_id", c), 32'(grant_id), 32'(src));
        chk($sformatf("rr c%0d in_tready", c), 32'(in_tready), 32'(1) << src);
      end
      adv = in_tready & in_tvalid;
      @(posedge clk); #1;
      for (int s = 0; s < 4; s++)
        if (adv[s]) w_idx[s] = (w_idx[s] == 3) ? 1 : w_idx[s] + 1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_stream_packet_arbiter.md
Name: axi_stream_packet_arbiter

Overview:
- Packet-granular round-robin arbiter that merges up to NUM_INPUTS 32-bit AXI Stream sources into one stream feeding the packet combiner.
- Holds a grant for a whole packet, so packets never interleave.
- Truncates runaway packets at MAX_PKT_LEN words.
- Generates the combiner's force_transmit flush pulse from an accumulation timeout, so low-rate traffic is not held indefinitely.

Parameters:
- NUM_INPUTS, 4: number of requesting streams; range 2..16.
- MAX_PKT_LEN, 64: maximum words per source packet before truncation; must be ≥1.
- FLUSH_TIMEOUT, 1024: cycles from the first word forwarded after a flush to the next force_transmit pulse; 0 disables flushing.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- in_tdata, input, NUM_INPUTS*32: source data; source i occupies bits [32*i+31:32*i].
- in_tvalid, input, NUM_INPUTS: per-source valid.
- in_tlast, input, NUM_INPUTS: per-source end of packet.
- in_tready, output, NUM_INPUTS: per-source ready.
- out_tdata, output, 32: muxed data to combiner.
- out_tvalid, output, 1: muxed valid.
- out_tlast, output, 1: muxed or forced last.
- out_tready, input, 1: combiner ready.
- force_transmit, output, 1: one-cycle flush request to combiner.
- grant_id, output, clog2(NUM_INPUTS): currently or last granted source.
- trunc_err, output, 1: one-cycle pulse on each truncation.

Behaviour:
- Reset state: FSM=IDLE; last_grant=NUM_INPUTS-1, so source 0 has first priority.
- Outputs during reset: in_tready=0, out_tvalid=0, out_tlast=0, out_tdata=0, force_transmit=0, grant_id=0, trunc_err=0.
- Reset mid-packet: the packet is abandoned immediately; no word is completed.
- Word counter: width clog2(MAX_PKT_LEN+1); flush timer: width clog2(FLUSH_TIMEOUT+1).
- FSM states: IDLE, GRANT, DRAIN.

IDLE:
- All in_tready=0 and out_tvalid=0.
- If any in_tvalid is set, select the first asserted index after last_grant, searching cyclically, wrapping NUM_INPUTS-1 to 0.
- Register it into g and grant_id, clear the word counter, and go to GRANT.
- This costs 1 bubble cycle per packet.

GRANT, data path:
- out_tdata=in_tdata[g], out_tvalid=in_tvalid[g], in_tready[g]=out_tready; all other in_tready=0. This path is combinational, with zero latency.
- out_tlast = in_tlast[g] OR (word counter == MAX_PKT_LEN-1).
- The word counter increments on each transfer (out_tvalid & out_tready).

GRANT, end of packet:
- On a transfer with in_tlast[g]=1, set last_grant=g and go to IDLE.
- On a transfer where the counter == MAX_PKT_LEN-1 and in_tlast[g]=0, force out_tlast, pulse trunc_err, and go to DRAIN.
- If in_tlast[g]=1 on exactly word MAX_PKT_LEN, this is a normal end: no truncation and no trunc_err.

DRAIN:
- in_tready[g]=1 and out_tvalid=0; words from source g are discarded.
- On a transfer with in_tlast[g]=1, set last_grant=g and go to IDLE.

Flush timer:
- pending is set on any output transfer.
- While pending, the timer increments every cycle.
- When timer == FLUSH_TIMEOUT-1, force_transmit=1 for one cycle; then clear timer and pending.
- A transfer in the same cycle as the pulse sets pending again for the next interval.
- If FLUSH_TIMEOUT=0, force_transmit stays 0 permanently.

Fairness and timing:
- A source that drops tvalid mid-packet keeps the grant; the arbiter waits.
- Every source with a waiting packet is served within NUM_INPUTS-1 other packets.
- out_tvalid and out_tdata are not registered, so the AXI rule that tdata is stable while tvalid & !tready is inherited from the source.

Test Plan:
- Fairness: sources 0..3 each continuously offer 3-word packets, out_tready=1 → output order 0,1,2,3,0,…; each packet is contiguous; 1 idle cycle between packets; out_tlast on every 3rd word.
- Single source: only source 2 valid, two 1-word packets → both forwarded with grant_id=2; out_tlast=1 on each word; other in_tready stay 0.
- Truncation: MAX_PKT_LEN=4, source 1 sends 7 words with tlast on word 7 → 4 words out, out_tlast on word 4, one trunc_err pulse; words 5–7 accepted and dropped; next grant goes to source 2 if it is valid.
- Exact length: MAX_PKT_LEN=4, source 0 sends exactly 4 words with tlast on word 4 → no trunc_err, no DRAIN, return to IDLE.
- Backpressure: out_tready toggles 1,0,1,0 during a 5-word packet → no word lost or duplicated; in_tready[g] mirrors out_tready; grant held throughout.
- Flush timer: FLUSH_TIMEOUT=8, one word forwarded at cycle T → force_transmit high exactly at cycle T+8 for one cycle, then no further pulse without new traffic. Rerun with FLUSH_TIMEOUT=0 → never asserted.
- Reset mid-packet: rst pulsed after word 2 of a 5-word packet → all outputs 0 during and after rst; next grant goes to source 0 if valid.
